// File: rtl/boot_seq_ctrl_if.sv
// Phase handshake bundle between the boot sequencer and the load engines
// (SPI preload, JTAG, SPI post-load, ...). One start/done pair per phase.
interface boot_seq_ctrl_if #(
    parameter int N_PHASES = 3
);
    logic [N_PHASES-1:0] phase_start;   // one-hot (or zero) phase enable
    logic [N_PHASES-1:0] phase_done;    // per-phase completion level

    // Sequencer side: drives the phase enables, watches completion
    modport master (output phase_start, input phase_done);
    // Engine side: follows the enable, reports completion
    modport slave  (input phase_start, output phase_done);
endinterface

// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: holds the SoC in reset, walks the load phases through
// start/done handshakes with idle gaps in between, retries the whole run
// after a phase timeout, and finally raises fetch enable (or parks in FAIL).
module boot_seq_ctrl #(
    parameter int N_PHASES       = 3,
    parameter int RST_CYCLES     = 10,
    parameter int GAP_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int MAX_RETRY      = 1,
    parameter int CNT_W          = 16
) (
    input  logic            s_clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    boot_seq_ctrl_if.master phase_if,
    output logic            soc_rst_no,
    output logic            fetch_enable_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [2:0]      cur_phase_o,
    output logic [2:0]      retry_cnt_o
);

    // Parameter sanity: refuse to elaborate configurations the counters cannot represent
    if (N_PHASES < 1 || N_PHASES > 8) begin : g_bad_phases
        $error("boot_seq_ctrl: N_PHASES must be 1..8");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("boot_seq_ctrl: CNT_W must be 1..32");
    end
    if (RST_CYCLES < 0 || GAP_CYCLES < 0 || TIMEOUT_CYCLES < 0) begin : g_bad_neg
        $error("boot_seq_ctrl: cycle parameters must be non-negative");
    end
    if (64'(RST_CYCLES) >= (64'd1 << CNT_W) || 64'(GAP_CYCLES) >= (64'd1 << CNT_W) ||
        64'(TIMEOUT_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_range
        $error("boot_seq_ctrl: a cycle parameter does not fit in CNT_W bits");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_retry
        $error("boot_seq_ctrl: MAX_RETRY must be 0..7");
    end

    // Zero-length intervals are stretched to one cycle; counters compare
    // against "last cycle" so an interval of L cycles ends on count L-1.
    localparam int RST_EFF = (RST_CYCLES < 1) ? 1 : RST_CYCLES;
    localparam int GAP_EFF = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int TO_EFF  = (TIMEOUT_CYCLES < 1) ? 1 : TIMEOUT_CYCLES;
    localparam bit TO_ON   = (TIMEOUT_CYCLES != 0);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_EFF - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       N_PH      = 4'(N_PHASES);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_GAP,
        S_PHASE,
        S_FETCH,
        S_FAIL
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [3:0]          r_idx;       // one wider than needed so it can reach N_PHASES=8
    logic [2:0]          r_retry;
    logic [N_PHASES-1:0] r_phase_start;
    logic                r_soc_rst_n;
    logic                r_fetch_en;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [2:0]          r_cur_phase;

    state_t              w_state_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [3:0]          w_idx_next;
    logic [2:0]          w_retry_next;
    logic [N_PHASES-1:0] w_done_hit;
    logic                w_cur_done;
    logic [N_PHASES-1:0] w_phase_start_next;
    logic [2:0]          w_cur_phase_next;

    // Only the active phase's done bit counts; the one-hot enable is decoded
    // from the next-state values so it is registered alongside the state.
    for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_phase
        assign w_done_hit[gi]         = phase_if.phase_done[gi] && (r_idx == 4'(gi));
        assign w_phase_start_next[gi] = (w_state_next == S_PHASE) && (w_idx_next == 4'(gi));
    end
    assign w_cur_done = |w_done_hit;

    // Next-state, counter, phase-index and retry logic; abort overrides everything
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_retry_next = r_retry;
        if (abort_i) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_idx_next   = '0;
            w_retry_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        w_state_next = S_RST;
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                        w_retry_next = '0;
                    end
                end
                S_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_state_next = S_GAP;
                        w_cnt_next   = '0;
                        w_idx_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = (r_idx < N_PH) ? S_PHASE : S_FETCH;
                    end else begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
                S_PHASE: begin
                    // Done is checked before the timeout so a late done still advances
                    if (w_cur_done) begin
                        w_state_next = S_GAP;
                        w_cnt_next   = '0;
                        w_idx_next   = r_idx + 4'd1;
                    end else if (TO_ON && (r_cnt == TO_LAST)) begin
                        w_cnt_next = '0;
                        if (r_retry < RETRY_MAX) begin
                            w_state_next = S_RST;
                            w_retry_next = r_retry + 3'd1;
                            w_idx_next   = '0;
                        end else begin
                            w_state_next = S_FAIL;   // idx kept: reports the failing phase
                        end
                    end else if (TO_ON) begin
                        w_cnt_next = r_cnt + CNT_ONE;
                    end
                end
                S_FETCH, S_FAIL: begin
                    // terminal until abort
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                    w_retry_next = '0;
                end
            endcase
        end
        w_cur_phase_next = (w_idx_next > 4'd7) ? 3'd7 : w_idx_next[2:0];
    end

    // State, counters and all outputs registered together on the same edge
    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_retry       <= '0;
            r_phase_start <= '0;
            r_soc_rst_n   <= 1'b0;
            r_fetch_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_cur_phase   <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_idx         <= w_idx_next;
            r_retry       <= w_retry_next;
            r_phase_start <= w_phase_start_next;
            r_soc_rst_n   <= (w_state_next == S_GAP) || (w_state_next == S_PHASE) ||
                             (w_state_next == S_FETCH);
            r_fetch_en    <= (w_state_next == S_FETCH);
            r_busy        <= (w_state_next == S_RST) || (w_state_next == S_GAP) ||
                             (w_state_next == S_PHASE);
            r_done        <= (w_state_next == S_FETCH);
            r_error       <= (w_state_next == S_FAIL);
            r_cur_phase   <= w_cur_phase_next;
        end
    end

    assign phase_if.phase_start = r_phase_start;
    assign soc_rst_no           = r_soc_rst_n;
    assign fetch_enable_o       = r_fetch_en;
    assign busy_o               = r_busy;
    assign done_o               = r_done;
    assign error_o              = r_error;
    assign cur_phase_o          = r_cur_phase;
    assign retry_cnt_o          = r_retry;

endmodule

// File: tb/tb_boot_seq_ctrl.sv
// Bench for boot_seq_ctrl. Two instances: A (RST=10, GAP=10, TIMEOUT=50,
// MAX_RETRY=1) for the nominal/timeout/abort scenarios, B (RST=0, GAP=0,
// no timeout) for the degenerate intervals and async reset.
// Expected output snapshots are queued with the cycle they must appear in;
// a negedge checker pops and compares them.
module tb_boot_seq_ctrl;

    logic clk;
    logic rst_n;
    logic start_a, abort_a, start_b, abort_b;
    logic soc_rst_n_a, fetch_a, busy_a, done_a, err_a;
    logic soc_rst_n_b, fetch_b, busy_b, done_b, err_b;
    logic [2:0] cp_a, rc_a, cp_b, rc_b;

    int cyc;
    int errors;
    int checks;

    typedef struct {
        int          cyc;
        int          which;
        logic [13:0] val;
        string       name;
    } exp_t;
    exp_t sb[$];

    boot_seq_ctrl_if #(.N_PHASES(3)) if_a ();
    boot_seq_ctrl_if #(.N_PHASES(3)) if_b ();

    boot_seq_ctrl #(
        .N_PHASES(3), .RST_CYCLES(10), .GAP_CYCLES(10),
        .TIMEOUT_CYCLES(50), .MAX_RETRY(1), .CNT_W(16)
    ) dut_a (
        .s_clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a),
        .phase_if(if_a.master),
        .soc_rst_no(soc_rst_n_a), .fetch_enable_o(fetch_a), .busy_o(busy_a),
        .done_o(done_a), .error_o(err_a), .cur_phase_o(cp_a), .retry_cnt_o(rc_a)
    );

    boot_seq_ctrl #(
        .N_PHASES(3), .RST_CYCLES(0), .GAP_CYCLES(0),
        .TIMEOUT_CYCLES(0), .MAX_RETRY(1), .CNT_W(8)
    ) dut_b (
        .s_clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b),
        .phase_if(if_b.master),
        .soc_rst_no(soc_rst_n_b), .fetch_enable_o(fetch_b), .busy_o(busy_b),
        .done_o(done_b), .error_o(err_b), .cur_phase_o(cp_b), .retry_cnt_o(rc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Snapshot layout: {phase_start[2:0], soc_rst_n, fetch, busy, done, error, cur_phase, retry}
    function automatic logic [13:0] mk(input logic [2:0] ps, input logic srn, input logic fe,
                                       input logic bsy, input logic dn, input logic er,
                                       input logic [2:0] cp, input logic [2:0] rc);
        return {ps, srn, fe, bsy, dn, er, cp, rc};
    endfunction

    function automatic logic [13:0] obs(input int which);
        if (which == 0)
            return {if_a.phase_start, soc_rst_n_a, fetch_a, busy_a, done_a, err_a, cp_a, rc_a};
        return {if_b.phase_start, soc_rst_n_b, fetch_b, busy_b, done_b, err_b, cp_b, rc_b};
    endfunction

    task automatic push(input int which, input int c, input logic [13:0] v, input string nm);
        exp_t e;
        e.cyc = c; e.which = which; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse_done_a(input int k, input int e);
        wait_until(e - 1);
        if_a.phase_done[k] = 1'b1;
        wait_until(e);
        if_a.phase_done[k] = 1'b0;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic abort_idle_a();
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
    endtask

    // Scoreboard: compare queued snapshots on the negedge of their cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [13:0] o;
            e = sb.pop_front();
            o = obs(e.which);
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: entry for cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (o !== e.val) begin
                errors++;
                $display("FAIL %s @%0d: got %b required %b", e.name, cyc, o, e.val);
            end
        end
    end

    task automatic test_reset();
        #12;
        checks++;
        if (obs(0) !== 14'd0) begin
            errors++;
            $display("FAIL reset_a: got %b required %b", obs(0), 14'd0);
        end
        checks++;
        if (obs(1) !== 14'd0) begin
            errors++;
            $display("FAIL reset_b: got %b required %b", obs(1), 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs(0) !== 14'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required %b", obs(0), 14'd0);
        end
    endtask

    task automatic test_nominal();
        int s;
        s = cyc + 1;
        push(0, s,      mk(3'b000, 0, 0, 1, 0, 0, 0, 0), "nom_rst_enter");
        push(0, s + 9,  mk(3'b000, 0, 0, 1, 0, 0, 0, 0), "nom_rst_hold");
        push(0, s + 10, mk(3'b000, 1, 0, 1, 0, 0, 0, 0), "nom_soc_release");
        push(0, s + 19, mk(3'b000, 1, 0, 1, 0, 0, 0, 0), "nom_gap0_hold");
        push(0, s + 20, mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "nom_ph0_start");
        push(0, s + 23, mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "nom_other_done_ignored");
        push(0, s + 24, mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "nom_ph0_hold");
        push(0, s + 25, mk(3'b000, 1, 0, 1, 0, 0, 1, 0), "nom_ph0_done");
        push(0, s + 34, mk(3'b000, 1, 0, 1, 0, 0, 1, 0), "nom_gap1_hold");
        push(0, s + 35, mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "nom_ph1_start");
        push(0, s + 40, mk(3'b000, 1, 0, 1, 0, 0, 2, 0), "nom_ph1_done");
        push(0, s + 50, mk(3'b100, 1, 0, 1, 0, 0, 2, 0), "nom_ph2_start");
        push(0, s + 55, mk(3'b000, 1, 0, 1, 0, 0, 3, 0), "nom_ph2_done");
        push(0, s + 64, mk(3'b000, 1, 0, 1, 0, 0, 3, 0), "nom_last_gap");
        push(0, s + 65, mk(3'b000, 1, 1, 0, 1, 0, 3, 0), "nom_fetch");
        push(0, s + 80, mk(3'b000, 1, 1, 0, 1, 0, 3, 0), "nom_fetch_hold");
        pulse_start_a();
        wait_until(s + 20);
        if_a.phase_done[2] = 1'b1;        // wrong phase: must be ignored
        wait_until(s + 22);
        if_a.phase_done[2] = 1'b0;
        pulse_done_a(0, s + 25);
        pulse_done_a(1, s + 40);
        pulse_done_a(2, s + 55);
        wait_until(s + 81);
    endtask

    task automatic test_timeout_retry();
        int s;
        abort_idle_a();
        s = cyc + 1;
        push(0, s + 35,  mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "tr_ph1_start");
        push(0, s + 84,  mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "tr_ph1_last");
        push(0, s + 85,  mk(3'b000, 0, 0, 1, 0, 0, 0, 1), "tr_timeout_rst");
        push(0, s + 94,  mk(3'b000, 0, 0, 1, 0, 0, 0, 1), "tr_rst_hold");
        push(0, s + 95,  mk(3'b000, 1, 0, 1, 0, 0, 0, 1), "tr_soc_release");
        push(0, s + 105, mk(3'b001, 1, 0, 1, 0, 0, 0, 1), "tr_ph0_again");
        push(0, s + 120, mk(3'b010, 1, 0, 1, 0, 0, 1, 1), "tr_ph1_again");
        push(0, s + 150, mk(3'b000, 1, 1, 0, 1, 0, 3, 1), "tr_fetch");
        pulse_start_a();
        pulse_done_a(0, s + 25);
        pulse_done_a(0, s + 110);
        pulse_done_a(1, s + 125);
        pulse_done_a(2, s + 140);
        wait_until(s + 151);
    endtask

    task automatic test_done_at_timeout();
        int s;
        abort_idle_a();
        s = cyc + 1;
        push(0, s + 84,  mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "dt_ph1_last");
        push(0, s + 85,  mk(3'b000, 1, 0, 1, 0, 0, 2, 0), "dt_done_wins");
        push(0, s + 95,  mk(3'b100, 1, 0, 1, 0, 0, 2, 0), "dt_ph2_start");
        push(0, s + 110, mk(3'b000, 1, 1, 0, 1, 0, 3, 0), "dt_fetch");
        pulse_start_a();
        pulse_done_a(0, s + 25);
        pulse_done_a(1, s + 85);
        pulse_done_a(2, s + 100);
        wait_until(s + 111);
    endtask

    task automatic test_abort();
        int s;
        int s2;
        int c;
        abort_idle_a();
        s = cyc + 1;
        push(0, s + 50, mk(3'b100, 1, 0, 1, 0, 0, 2, 0), "ab_ph2_start");
        push(0, s + 52, 14'd0, "ab_abort_in_phase");
        pulse_start_a();
        pulse_done_a(0, s + 25);
        pulse_done_a(1, s + 40);
        wait_until(s + 51);
        abort_a = 1'b1;
        wait_until(s + 52);
        abort_a = 1'b0;
        wait_until(s + 53);
        s2 = cyc + 1;
        push(0, s2,      mk(3'b000, 0, 0, 1, 0, 0, 0, 0), "ab_restart_rst");
        push(0, s2 + 10, mk(3'b000, 1, 0, 1, 0, 0, 0, 0), "ab_restart_release");
        push(0, s2 + 20, mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "ab_restart_ph0");
        push(0, s2 + 65, mk(3'b000, 1, 1, 0, 1, 0, 3, 0), "ab_restart_fetch");
        push(0, s2 + 70, 14'd0, "ab_abort_in_fetch");
        pulse_start_a();
        pulse_done_a(0, s2 + 25);
        pulse_done_a(1, s2 + 40);
        pulse_done_a(2, s2 + 55);
        wait_until(s2 + 69);
        abort_a = 1'b1;
        wait_until(s2 + 70);
        abort_a = 1'b0;
        wait_until(s2 + 72);
        c = cyc;
        push(0, c + 1, 14'd0, "ab_start_and_abort");
        push(0, c + 2, 14'd0, "ab_start_and_abort_hold");
        start_a = 1'b1;
        abort_a = 1'b1;
        wait_until(c + 1);
        start_a = 1'b0;
        abort_a = 1'b0;
        wait_until(c + 3);
    endtask

    task automatic test_exhausted();
        int s;
        abort_idle_a();
        s = cyc + 1;
        push(0, s + 84,  mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "ex_ph1_last");
        push(0, s + 85,  mk(3'b000, 0, 0, 1, 0, 0, 0, 1), "ex_retry_rst");
        push(0, s + 120, mk(3'b010, 1, 0, 1, 0, 0, 1, 1), "ex_ph1_again");
        push(0, s + 169, mk(3'b010, 1, 0, 1, 0, 0, 1, 1), "ex_ph1_again_last");
        push(0, s + 170, mk(3'b000, 0, 0, 0, 0, 1, 1, 1), "ex_fail");
        push(0, s + 190, mk(3'b000, 0, 0, 0, 0, 1, 1, 1), "ex_fail_hold");
        pulse_start_a();
        pulse_done_a(0, s + 25);
        pulse_done_a(0, s + 110);
        wait_until(s + 191);
    endtask

    task automatic test_degenerate_b();
        int s;
        s = cyc + 1;
        push(1, s,       mk(3'b000, 0, 0, 1, 0, 0, 0, 0), "dg_rst_1cyc");
        push(1, s + 1,   mk(3'b000, 1, 0, 1, 0, 0, 0, 0), "dg_gap_1cyc");
        push(1, s + 2,   mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "dg_ph0_start");
        push(1, s + 3,   mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "dg_ph0_hold");
        push(1, s + 4,   mk(3'b000, 1, 0, 1, 0, 0, 1, 0), "dg_ph0_done");
        push(1, s + 5,   mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "dg_ph1_start");
        push(1, s + 105, mk(3'b010, 1, 0, 1, 0, 0, 1, 0), "dg_no_timeout");
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_until(s + 3);
        if_b.phase_done[0] = 1'b1;
        wait_until(s + 4);
        if_b.phase_done[0] = 1'b0;
        wait_until(s + 106);
    endtask

    // Async reset mid-phase on B while A sits in FAIL with a retry consumed
    task automatic test_async_reset();
        int s;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs(1) !== 14'd0) begin
            errors++;
            $display("FAIL async_reset_b: got %b required %b", obs(1), 14'd0);
        end
        checks++;
        if (obs(0) !== 14'd0) begin
            errors++;
            $display("FAIL async_reset_a: got %b required %b", obs(0), 14'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s = cyc + 1;
        push(1, s,     mk(3'b000, 0, 0, 1, 0, 0, 0, 0), "ar_restart_rst");
        push(1, s + 2, mk(3'b001, 1, 0, 1, 0, 0, 0, 0), "ar_restart_ph0");
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_until(s + 3);
    endtask

    initial begin
        cyc = 0;
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        if_a.phase_done = '0;
        if_b.phase_done = '0;
        test_reset();
        test_nominal();
        test_timeout_retry();
        test_done_at_timeout();
        test_abort();
        test_exhausted();
        test_degenerate_b();
        test_async_reset();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boot_seq_ctrl.md
# boot_seq_ctrl

Parametrised boot sequencer that drives a PULPino-class SoC from reset to code execution. It holds SoC reset for a programmable interval, then runs N load phases (SPI preload, JTAG, SPI post-load, …) in order through start/done handshakes, with programmable inter-phase gaps, per-phase timeout, and bounded retry. On success it asserts fetch enable; on exhausted retries it parks in a fail state. It sits in the FPGA test wrapper between the test controller and the SPI/JTAG driver engines and the SoC reset/fetch pins.

## Interface
- N_PHASES, 3, number of handshaked load phases (1..8)
- RST_CYCLES, 10, cycles SoC reset is held low after start (0 treated as 1)
- GAP_CYCLES, 10, idle cycles before each phase and before fetch (0 treated as 1)
- TIMEOUT_CYCLES, 0, max cycles in a phase waiting for done; 0 disables timeout
- MAX_RETRY, 1, full restarts (from RST) allowed after a timeout
- CNT_W, 16, delay/timeout counter width; elaboration error if any cycle parameter ≥ 2^CNT_W
- s_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  begin sequence; sampled only in IDLE
- abort_i  in  1  return to IDLE from any state; highest priority
- phase_done_i  in  N_PHASES  per-phase completion, level, sampled only for active phase
- phase_start_o  out  N_PHASES  one-hot (or zero) phase enable, held for the whole phase
- soc_rst_no  out  1  SoC active-low reset
- fetch_enable_o  out  1  SoC fetch enable
- busy_o  out  1  high in RST, GAP, PHASE
- done_o  out  1  high in FETCH
- error_o  out  1  high in FAIL
- cur_phase_o  out  3  index of current/next phase
- retry_cnt_o  out  3  retries consumed in this run

## Operation
- States: IDLE, RST, GAP, PHASE, FETCH, FAIL. Single counter cnt (CNT_W), phase index idx, retry counter.
- IDLE: soc_rst_no=0. start_i=1 → RST; idx, cnt, retry cleared.
- RST: soc_rst_no=0; after max(RST_CYCLES,1) cycles → GAP, idx=0, cnt cleared.
- GAP: soc_rst_no=1; after max(GAP_CYCLES,1) cycles → PHASE if idx<N_PHASES, else FETCH.
- PHASE: phase_start_o[idx]=1. phase_done_i[idx]=1 → GAP, idx+1. Other done bits ignored. If TIMEOUT_CYCLES≠0 and cnt reaches TIMEOUT_CYCLES without done: retry<MAX_RETRY → RST, retry+1, idx=0; else → FAIL.
- FETCH: soc_rst_no=1, fetch_enable_o=1, done_o=1; terminal until abort_i.
- FAIL: soc_rst_no=0, error_o=1, cur_phase_o frozen at failing phase; terminal until abort_i.
- abort_i=1 in any state → IDLE next edge; retry, idx, cnt cleared. start_i and abort_i both high in IDLE → stay IDLE.
- Done and timeout in the same cycle: done wins.

## Timing
- All outputs registered; they change on the same edge as the state register. No combinational input-to-output path.
- Reset values: state IDLE, soc_rst_no=0, phase_start_o=0, fetch_enable_o=0, busy_o=0, done_o=0, error_o=0, cur_phase_o=0, retry_cnt_o=0.
- start_i high at edge t → RST from t; soc_rst_no rises at edge t+max(RST_CYCLES,1).
- Phase k start asserts exactly max(GAP_CYCLES,1) cycles after soc_rst_no rise (k=0) or after the edge sampling done for phase k−1.
- phase_done_i sampled at edge e → phase_start_o[k] deasserts at e; no next start before e+max(GAP_CYCLES,1).
- Timeout: phase_start_o high for exactly TIMEOUT_CYCLES cycles, then RST or FAIL.
- fetch_enable_o rises max(GAP_CYCLES,1) cycles after last done sample.
- Async rst_n assertion mid-run forces reset values immediately; no retry credit retained.

## Test plan
- Nominal, N_PHASES=3, RST=10, GAP=10: start at cycle 0 → soc_rst_no rises cycle 10, phase_start_o=001 at 20; done after 5 → 010 at 35; … fetch_enable_o=1 after last gap, done_o=1.
- Timeout with retry, TIMEOUT=50, MAX_RETRY=1: phase 1 never done → start 010 for 50 cycles, soc_rst_no low 10 cycles, retry_cnt_o=1; second run completes → done_o=1.
- Exhausted retry, same config, phase 1 never done twice → error_o=1, cur_phase_o=1, soc_rst_no=0, retry_cnt_o=1.
- Done coincident with timeout cycle → phase advances, no retry.
- abort_i in PHASE 2 and in FETCH → IDLE next cycle, all outputs at reset values; new start_i runs full sequence.
- RST_CYCLES=0, GAP_CYCLES=0 → each lasts exactly 1 cycle; rst_n pulsed mid-phase → immediate reset values.
